control_pipe: RTL and testbench
===============================

Name: control_pipe

Overview:
- Pipelined successor to the single-cycle MIPS control decoder.
- Decodes a 6-bit opcode into EX/M/WB control bundles and carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Supports stall (bubble) and flush (squash) requests and flags illegal opcodes.
- Sits between the IF/ID register and the datapath stage registers in the 5-stage pipeline.

Parameters:
- OPW, 6: opcode width.
- CNT_W, 8: width of the saturating illegal-opcode counter.
- RTYPE_OP, 6'b000000: R-type opcode.
- LW_OP, 6'b100011: load word opcode.
- SW_OP, 6'b101011: store word opcode.
- BEQ_OP, 6'b000100: branch-equal opcode.
- NOP_OP, 6'b100000: explicit NOP opcode.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- opcode  in  OPW  opcode of the instruction in ID.
- in_valid  in  1  opcode is a real instruction this cycle.
- stall  in  1  load-use hazard; insert a bubble into ID/EX.
- flush  in  1  branch taken; squash the ID and EX instructions.
- ex_ctl  out  4  ID/EX EX bundle {RegDst, ALUOp[1:0], ALUSrc}.
- ex_vld  out  1  ID/EX holds a real instruction.
- m_ctl  out  3  EX/MEM M bundle {Branch, MemRead, MemWrite}.
- m_vld  out  1  EX/MEM holds a real instruction.
- wb_ctl  out  2  MEM/WB WB bundle {RegWrite, MemToReg}.
- wb_vld  out  1  MEM/WB holds a real instruction.
- illegal  out  1  one-cycle pulse: an unrecognised opcode was dropped.
- err_cnt  out  CNT_W  saturating count of illegal opcodes.

Behaviour:
- Reset: on a clk edge with rst_n=0, every output and every internal register goes to 0. A reset asserted mid-operation discards all in-flight bundles. No initial blocks.
- Decode (combinational, internal). Don't-care bits are driven 0, never Z or X.
  - RTYPE: EX=1100, M=000, WB=10.
  - LW: EX=0001, M=010, WB=11.
  - SW: EX=0001, M=001, WB=00.
  - BEQ: EX=0010, M=100, WB=00.
  - NOP: all zero, valid=1.
  - Any other opcode: illegal.
- Bubble: all control bits 0 and valid=0.
- ID/EX update each edge, in priority order:
  - flush: bubble.
  - else stall: bubble.
  - else in_valid=0: bubble.
  - else illegal opcode: bubble.
  - else the decoded EX/M/WB with valid=1.
- EX/MEM update:
  - flush: bubble.
  - else loads the M and WB parts plus valid from ID/EX.
- MEM/WB update: always loads the WB part plus valid from EX/MEM. The branch that raised flush completes normally.
- Latency: an opcode accepted at edge N appears on ex_ctl in cycle N+1, m_ctl in N+2 and wb_ctl in N+3.
- Stall holds nothing in this block; upstream holds IF/ID. Older instructions keep advancing.
- flush and stall together: flush wins.
- Illegal opcode:
  - Counts only when in_valid=1 and neither flush nor stall is active.
  - illegal is registered and high for exactly the cycle after the offending edge.
  - err_cnt increments by 1 and saturates at 2^CNT_W-1 (no wrap). It is cleared only by reset.

Optional Feature:
- Macro: CONTROL_PIPE_ADDI_EN.
- Defined: opcode 6'b001000 (ADDI) decodes to EX=0001, M=000, WB=10, valid=1.
- Undefined: 6'b001000 is treated as illegal (bubble, illegal pulse, err_cnt increments).

Test Plan:
- Reset then stream: rst_n=0 for 2 cycles, then in_valid=1 with opcodes RTYPE, LW, SW, BEQ on consecutive cycles. Expect ex_ctl = 1100, 0001, 0001, 0010 starting one cycle after the first accept. Expect m_ctl = 000, 010, 001, 100 one cycle later and wb_ctl = 10, 11, 00, 00 one cycle after that, with the matching *_vld bits high.
- Stall: LW accepted, then RTYPE presented with stall=1 for one cycle. Expect a bubble in ex_ctl (0000, ex_vld=0) while the LW moves on with m_ctl=010. The re-presented RTYPE yields ex_ctl=1100 a cycle later.
- Flush: BEQ, RTYPE, LW accepted back to back; assert flush in the cycle BEQ is in EX/MEM (m_ctl=100). Next cycle: ex_vld=0, m_vld=0, and wb_vld=1 with wb_ctl=00 for the BEQ. Also assert stall in the same cycle; the result must be identical.
- Illegal opcode: in_valid=1, opcode=6'b111111. Expect illegal=1 for exactly one cycle, err_cnt 0→1, and ex_vld=0. With CNT_W=2, five illegal opcodes leave err_cnt=3.
- Reset mid-flight: pull rst_n low while LW is in EX/MEM. After that edge all outputs are 0, including err_cnt.
- ADDI: opcode 6'b001000 gives ex_ctl=0001, wb_ctl=10 with the macro defined; without the macro it gives illegal=1.

Source files
------------

// File: rtl/control_pipe.sv
// Pipelined MIPS control: decodes opcode into EX/M/WB bundles carried through ID/EX, EX/MEM, MEM/WB.
// Optional ADDI decode is enabled by defining CONTROL_PIPE_ADDI_EN.
module control_pipe #(
    parameter int OPW = 6,
    parameter int CNT_W = 8,
    parameter logic [OPW-1:0] RTYPE_OP = 6'b000000,
    parameter logic [OPW-1:0] LW_OP = 6'b100011,
    parameter logic [OPW-1:0] SW_OP = 6'b101011,
    parameter logic [OPW-1:0] BEQ_OP = 6'b000100,
    parameter logic [OPW-1:0] NOP_OP = 6'b100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPW-1:0]   opcode,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [3:0]       ex_ctl,
    output logic             ex_vld,
    output logic [2:0]       m_ctl,
    output logic             m_vld,
    output logic [1:0]       wb_ctl,
    output logic             wb_vld,
    output logic             illegal,
    output logic [CNT_W-1:0] err_cnt
);

`ifdef CONTROL_PIPE_ADDI_EN
    localparam logic [OPW-1:0] ADDI_OP = 6'b001000;
`endif

    logic [3:0] dec_ex;
    logic [2:0] dec_m;
    logic [1:0] dec_wb;
    logic       dec_legal;

    always_comb begin
        dec_ex    = 4'b0000;
        dec_m     = 3'b000;
        dec_wb    = 2'b00;
        dec_legal = 1'b1;
        unique case (1'b1)
            (opcode == RTYPE_OP): begin
                dec_ex = 4'b1100;
                dec_wb = 2'b10;
            end
            (opcode == LW_OP): begin
                dec_ex = 4'b0001;
                dec_m  = 3'b010;
                dec_wb = 2'b11;
            end
            (opcode == SW_OP): begin
                dec_ex = 4'b0001;
                dec_m  = 3'b001;
            end
            (opcode == BEQ_OP): begin
                dec_ex = 4'b0010;
                dec_m  = 3'b100;
            end
            (opcode == NOP_OP): begin
                dec_ex = 4'b0000;
            end
`ifdef CONTROL_PIPE_ADDI_EN
            (opcode == ADDI_OP): begin
                dec_ex = 4'b0001;
                dec_wb = 2'b10;
            end
`endif
            default: dec_legal = 1'b0;
        endcase
    end

    logic [3:0]       idex_ex_q, idex_ex_d;
    logic [2:0]       idex_m_q, idex_m_d;
    logic [1:0]       idex_wb_q, idex_wb_d;
    logic             idex_vld_q, idex_vld_d;
    logic [2:0]       exmem_m_q, exmem_m_d;
    logic [1:0]       exmem_wb_q, exmem_wb_d;
    logic             exmem_vld_q, exmem_vld_d;
    logic [1:0]       memwb_wb_q, memwb_wb_d;
    logic             memwb_vld_q, memwb_vld_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             accept;

    // Only an instruction that would otherwise enter ID/EX can be flagged illegal.
    assign accept = in_valid && !flush && !stall;

    always_comb begin
        idex_ex_d   = 4'b0000;
        idex_m_d    = 3'b000;
        idex_wb_d   = 2'b00;
        idex_vld_d  = 1'b0;
        if (accept && dec_legal) begin
            idex_ex_d  = dec_ex;
            idex_m_d   = dec_m;
            idex_wb_d  = dec_wb;
            idex_vld_d = 1'b1;
        end
        exmem_m_d   = 3'b000;
        exmem_wb_d  = 2'b00;
        exmem_vld_d = 1'b0;
        if (!flush) begin
            exmem_m_d   = idex_m_q;
            exmem_wb_d  = idex_wb_q;
            exmem_vld_d = idex_vld_q;
        end
        memwb_wb_d  = exmem_wb_q;
        memwb_vld_d = exmem_vld_q;
        illegal_d   = accept && !dec_legal;
        err_cnt_d   = err_cnt_q;
        if (illegal_d && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_ex_q   <= '0;
            idex_m_q    <= '0;
            idex_wb_q   <= '0;
            idex_vld_q  <= 1'b0;
            exmem_m_q   <= '0;
            exmem_wb_q  <= '0;
            exmem_vld_q <= 1'b0;
            memwb_wb_q  <= '0;
            memwb_vld_q <= 1'b0;
            illegal_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            idex_ex_q   <= idex_ex_d;
            idex_m_q    <= idex_m_d;
            idex_wb_q   <= idex_wb_d;
            idex_vld_q  <= idex_vld_d;
            exmem_m_q   <= exmem_m_d;
            exmem_wb_q  <= exmem_wb_d;
            exmem_vld_q <= exmem_vld_d;
            memwb_wb_q  <= memwb_wb_d;
            memwb_vld_q <= memwb_vld_d;
            illegal_q   <= illegal_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign ex_ctl  = idex_ex_q;
    assign ex_vld  = idex_vld_q;
    assign m_ctl   = exmem_m_q;
    assign m_vld   = exmem_vld_q;
    assign wb_ctl  = memwb_wb_q;
    assign wb_vld  = memwb_vld_q;
    assign illegal = illegal_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
// Randomized bench for control_pipe against a time-indexed history model.
// Honours CONTROL_PIPE_ADDI_EN to match the DUT build.
module tb_control_pipe;

    localparam int CW = 2;
    localparam int N = 4096;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, stall, flush;
    logic [5:0]    opcode;
    logic [3:0]    ex_ctl;
    logic          ex_vld;
    logic [2:0]    m_ctl;
    logic          m_vld;
    logic [1:0]    wb_ctl;
    logic          wb_vld;
    logic          illegal;
    logic [CW-1:0] err_cnt;

    control_pipe #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .in_valid(in_valid),
        .stall(stall), .flush(flush), .ex_ctl(ex_ctl), .ex_vld(ex_vld),
        .m_ctl(m_ctl), .m_vld(m_vld), .wb_ctl(wb_ctl), .wb_vld(wb_vld),
        .illegal(illegal), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ex;
        logic [2:0] m;
        logic [1:0] wb;
        logic       vld;
    } bun_t;

    // acc[k]: bundle that entered ID/EX at edge k; kill_m[k]: EX/MEM cleared at edge k.
    bun_t acc[N];
    bit   kill_m[N];
    bit   rst_h[N];
    int   k = 2;
    int   cnt = 0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    function automatic bun_t dec(input logic [5:0] op, output bit legal);
        legal = 1'b1;
        case (op)
            6'b000000: dec = {4'b1100, 3'b000, 2'b10, 1'b1};
            6'b100011: dec = {4'b0001, 3'b010, 2'b11, 1'b1};
            6'b101011: dec = {4'b0001, 3'b001, 2'b00, 1'b1};
            6'b000100: dec = {4'b0010, 3'b100, 2'b00, 1'b1};
            6'b100000: dec = {4'b0000, 3'b000, 2'b00, 1'b1};
`ifdef CONTROL_PIPE_ADDI_EN
            6'b001000: dec = {4'b0001, 3'b000, 2'b10, 1'b1};
`endif
            default: begin
                dec = '0;
                legal = 1'b0;
            end
        endcase
    endfunction

    task automatic step(input logic r, input logic v, input logic s,
                        input logic f, input logic [5:0] op);
        bun_t d, em, mw;
        bit   lg, ill;
        rst_n = r;
        in_valid = v;
        stall = s;
        flush = f;
        opcode = op;
        @(posedge clk);
        d = dec(op, lg);
        rst_h[k] = !r;
        kill_m[k] = !r || f;
        acc[k] = (!r || f || s || !v || !lg) ? '0 : d;
        ill = r && v && !f && !s && !lg;
        if (!r) cnt = 0;
        else if (ill && cnt < (1 << CW) - 1) cnt++;
        em = kill_m[k] ? '0 : acc[k-1];
        mw = (rst_h[k] || kill_m[k-1]) ? '0 : acc[k-2];
        #1;
        chk("ex_ctl", ex_ctl, acc[k].ex);
        chk("ex_vld", ex_vld, acc[k].vld);
        chk("m_ctl", m_ctl, em.m);
        chk("m_vld", m_vld, em.vld);
        chk("wb_ctl", wb_ctl, mw.wb);
        chk("wb_vld", wb_vld, mw.vld);
        chk("illegal", illegal, ill);
        chk("err_cnt", err_cnt, cnt);
        k++;
    endtask

    localparam logic [5:0] R = 6'b000000;
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100;
    localparam logic [5:0] NP = 6'b100000;
    localparam logic [5:0] AD = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    initial begin
        logic [5:0] ops[7];
        kill_m[0] = 1'b1;
        kill_m[1] = 1'b1;
        ops[0] = R; ops[1] = LW; ops[2] = SW; ops[3] = BQ;
        ops[4] = NP; ops[5] = AD; ops[6] = BAD;

        step(0, 0, 0, 0, R);
        step(0, 0, 0, 0, R);
        chk("rst_cnt", err_cnt, 0);

        step(1, 1, 0, 0, R);
        chk("stream_ex0", ex_ctl, 4'b1100);
        step(1, 1, 0, 0, LW);
        step(1, 1, 0, 0, SW);
        step(1, 1, 0, 0, BQ);
        chk("stream_m3", m_ctl, 3'b001);
        step(1, 0, 0, 0, R);
        chk("stream_wb3", wb_ctl, 2'b00);
        step(1, 0, 0, 0, R);

        step(1, 1, 0, 0, LW);
        step(1, 1, 1, 0, R);
        chk("stall_bub", ex_vld, 1'b0);
        chk("stall_lw_m", m_ctl, 3'b010);
        step(1, 1, 0, 0, R);
        chk("stall_rep", ex_ctl, 4'b1100);
        step(1, 0, 0, 0, R);

        for (int rep = 0; rep < 2; rep++) begin
            step(1, 1, 0, 0, BQ);
            step(1, 1, 0, 0, R);
            chk("flush_beq_m", m_ctl, 3'b100);
            step(1, 1, rep[0], 1, LW);
            chk("flush_exv", ex_vld, 1'b0);
            chk("flush_mv", m_vld, 1'b0);
            chk("flush_wbv", wb_vld, 1'b1);
            step(1, 0, 0, 0, R);
            step(1, 0, 0, 0, R);
        end

        step(1, 1, 0, 0, BAD);
        chk("ill_pulse", illegal, 1'b1);
        step(1, 0, 0, 0, R);
        chk("ill_once", illegal, 1'b0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, BAD);
        chk("ill_sat", err_cnt, 2'd3);

        step(1, 1, 0, 0, LW);
        step(1, 0, 0, 0, R);
        step(0, 1, 0, 0, SW);
        chk("rst_mid_cnt", err_cnt, 0);
        chk("rst_mid_m", m_vld, 1'b0);

        step(1, 1, 0, 0, AD);
`ifdef CONTROL_PIPE_ADDI_EN
        chk("addi_ex", ex_ctl, 4'b0001);
`else
        chk("addi_ill", illegal, 1'b1);
`endif
        step(1, 0, 0, 0, R);
        step(1, 0, 0, 0, R);

        for (int i = 0; i < 1500; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), op);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
